truth_table_sweeper: RTL and testbench

Self-checking stimulus stage placed directly upstream of a 3-input combinational logic block such as `m0xC5`. It drives `in1`/`in2`/`in3` through all eight input combinations and waits a programmable settle time at each one. It then samples the block's single output and assembles the observed 8-bit truth vector, which it compares against an expected code. The block is used for on-chip or bench characterisation of synthesised logic circuits.

---
 rtl/truth_sweep_pkg.sv | 19 +
 rtl/sweep_timer.sv | 26 ++
 rtl/truth_table_sweeper.sv | 154 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper and its timer.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  localparam int IDX_W = 3;
  localparam int VEC_W = 8;

  // idx 0 lands in the vector MSB so the vector reads like a hex function code.
  function automatic logic [IDX_W-1:0] vec_bit_pos(input logic [IDX_W-1:0] idx);
    return IDX_W'(VEC_W - 1 - int'(idx));
  endfunction

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter; tc is high while the count is zero.
module sweep_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input block through all eight input codes, samples its output
// and reports the observed truth vector against a reference code.
//
// Handshake: start is a level request sampled only in IDLE; a high start on an
// IDLE edge is accepted, busy then stays high through the DONE cycle, and done
// is a single-cycle pulse with table_o/match/unstable already valid.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int                 SETTLE_CYCLES = 4,
  parameter int                 SAMPLES       = 3,
  parameter logic [VEC_W-1:0]   EXPECTED      = 8'hC5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic             in1,
  output logic             in2,
  output logic             in3,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] table_o,
  output logic             match,
  output logic             unstable,
  output sweep_state_t     dbg_state
);

  localparam int MAX_CNT = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int TW      = $clog2(MAX_CNT + 1);
  localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    SAMPLE_LD = TW'(SAMPLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_W - 1);

  sweep_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [VEC_W-1:0] r_shadow_vec, w_vec_nxt;
  logic             r_shadow_unst, w_unst_nxt;
  logic             r_first, r_bit, w_bit, w_glitch;
  logic [VEC_W-1:0] r_table;
  logic             r_match, r_unstable;
  logic             w_tmr_load, w_tc;
  logic [TW-1:0]    w_tmr_val;

  sweep_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = SETTLE_LD;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_load  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_tc) begin
          w_state_nxt = ST_SAMPLE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = SAMPLE_LD;
        end
      end
      ST_SAMPLE: begin
        if (w_tc) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_tmr_load  = 1'b1;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The first capture defines the bit; later captures only flag instability.
  always_comb begin
    w_bit      = r_first ? dut_out : r_bit;
    w_glitch   = (r_state == ST_SAMPLE) && !r_first && (dut_out != r_bit);
    w_unst_nxt = r_shadow_unst | w_glitch;
    w_vec_nxt  = r_shadow_vec;
    w_vec_nxt[vec_bit_pos(r_idx)] = w_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_shadow_vec  <= '0;
      r_shadow_unst <= 1'b0;
      r_first       <= 1'b0;
      r_bit         <= 1'b0;
      r_table       <= '0;
      r_match       <= 1'b0;
      r_unstable    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx         <= '0;
            r_shadow_vec  <= '0;
            r_shadow_unst <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_tc) r_first <= 1'b1;
        end
        ST_SAMPLE: begin
          r_shadow_unst <= w_unst_nxt;
          if (r_first) begin
            r_bit   <= dut_out;
            r_first <= 1'b0;
          end
          if (w_tc) begin
            r_shadow_vec <= w_vec_nxt;
            // Results load on the edge entering DONE so they are valid with done.
            if (r_idx == LAST_IDX) begin
              r_table    <= w_vec_nxt;
              r_match    <= (w_vec_nxt == EXPECTED);
              r_unstable <= w_unst_nxt;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_DONE: r_idx <= '0;
        default: r_idx <= '0;
      endcase
    end
  end

  assign {in1, in2, in3} = r_idx;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign table_o   = r_table;
  assign match     = r_match;
  assign unstable  = r_unstable;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Table-driven bench for truth_table_sweeper with a behavioural logic block.
module tb_truth_table_sweeper;
  import truth_sweep_pkg::*;

  logic clk, rst_n;
  logic start, dut_out, in1, in2, in3, busy, done, match, unstable;
  logic [7:0] table_o;
  sweep_state_t dbg_state;

  logic start_m, dut_out_m, in1_m, in2_m, in3_m, busy_m, done_m, match_m, unstable_m;
  logic [7:0] table_m;
  sweep_state_t dbg_state_m;

  int n_cmp = 0;
  int n_fail = 0;
  int mode = 0;
  logic glitch_en = 1'b0;
  int since = 0;
  logic [2:0] prev_stim = 3'd0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  truth_table_sweeper u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
    .table_o(table_o), .match(match), .unstable(unstable), .dbg_state(dbg_state)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .SAMPLES(1), .EXPECTED(8'hC5)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .start(start_m), .dut_out(dut_out_m),
    .in1(in1_m), .in2(in2_m), .in3(in3_m), .busy(busy_m), .done(done_m),
    .table_o(table_m), .match(match_m), .unstable(unstable_m), .dbg_state(dbg_state_m)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- logic block under test ----------------
  function automatic logic blk(input int m, input logic [2:0] s);
    logic [7:0] c5;
    c5 = 8'hC5;
    case (m)
      0:       return c5[3'd7 - s];
      1:       return &s;
      2:       return |s;
      3:       return ^s;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if ({in1, in2, in3} != prev_stim) begin
      since = 0;
      prev_stim = {in1, in2, in3};
    end else begin
      since = since + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  // Glitch lands in the cycle captured by the second sample of idx 2.
  always_comb dut_out = blk(mode, {in1, in2, in3}) ^
                        (glitch_en && ({in1, in2, in3} == 3'd2) && (since == 5));
  always_comb dut_out_m = blk(0, {in1_m, in2_m, in3_m});

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses start, waits for done; returns cycles from the accept edge to done.
  task automatic run_sweep(input int poke_at, output int lat);
    logic [7:0] tbl_before;
    logic busy_drop, held_bad;
    tbl_before = table_o;
    busy_drop = 1'b0;
    held_bad = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    check("busy_rise", busy, 1);
    while (!done && lat < 300) begin
      if (lat == poke_at) start = 1'b1;
      if (lat == poke_at + 1) start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_drop = 1'b1;
      if (!done && table_o !== tbl_before) held_bad = 1'b1;
    end
    start = 1'b0;
    check("busy_continuous", busy_drop, 0);
    check("result_hold", held_bad, 0);
  endtask

  typedef struct {
    int         mode;
    logic       glitch;
    logic [7:0] exp_table;
    logic       exp_match;
    logic       exp_unst;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    logic [7:0] exp_tbl;

    vecs[0] = '{0, 1'b0, 8'hC5, 1'b1, 1'b0};  // m0xC5
    vecs[1] = '{1, 1'b0, 8'h01, 1'b0, 1'b0};  // AND3
    vecs[2] = '{0, 1'b1, 8'hC5, 1'b1, 1'b1};  // m0xC5 with glitch at idx 2
    vecs[3] = '{0, 1'b0, 8'hC5, 1'b1, 1'b0};  // unstable clears on next sweep
    vecs[4] = '{2, 1'b0, 8'h7F, 1'b0, 1'b0};  // OR3
    vecs[5] = '{3, 1'b0, 8'h69, 1'b0, 1'b0};  // XOR3

    rst_n = 1'b0;
    start = 1'b0;
    start_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stim", {in1, in2, in3}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_table", table_o, 0);
    check("rst_match", match, 0);
    check("rst_unstable", unstable, 0);
    check("rst_min_busy", busy_m, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      glitch_en = vecs[i].glitch;
      exp_q.push_back(vecs[i].exp_table);
      run_sweep(-1, lat);
      exp_tbl = exp_q.pop_front();
      check($sformatf("latency[%0d]", i), lat, 56);
      check($sformatf("table[%0d]", i), table_o, exp_tbl);
      check($sformatf("match[%0d]", i), match, vecs[i].exp_match);
      check($sformatf("unstable[%0d]", i), unstable, vecs[i].exp_unst);
      if (vecs[i].glitch) check("glitch_bit5", table_o[5], 0);
      @(posedge clk); #1;
      check($sformatf("done_fall[%0d]", i), done, 0);
      check($sformatf("busy_fall[%0d]", i), busy, 0);
    end
    glitch_en = 1'b0;

    // start re-asserted mid-sweep must be ignored
    mode = 1;
    done_cnt = 0;
    run_sweep(10, lat);
    check("busy_start_latency", lat, 56);
    check("busy_start_table", table_o, 8'h01);
    repeat (80) @(posedge clk);
    #1;
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_idle", busy, 0);

    // reset during idx 4 aborts without a done pulse
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if ({in1, in2, in3} == 3'd4) break;
      @(posedge clk); #1;
    end
    check("reach_idx4", {in1, in2, in3}, 4);
    done_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_stim", {in1, in2, in3}, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_table", table_o, 0);
    check("abort_match", match, 0);
    check("abort_unstable", unstable, 0);
    check("abort_state", dbg_state, ST_IDLE);
    @(negedge clk) rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    run_sweep(-1, lat);
    check("after_abort_latency", lat, 56);
    check("after_abort_table", table_o, 8'hC5);
    check("after_abort_match", match, 1);

    // minimum parameters: each code held two cycles, done 16 edges after accept
    @(negedge clk) start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("min_stim[%0d]", k), {in1_m, in2_m, in3_m}, k / 2);
      check($sformatf("min_nodone[%0d]", k), done_m, 0);
      @(posedge clk); #1;
    end
    check("min_done", done_m, 1);
    check("min_table", table_m, 8'hC5);
    check("min_match", match_m, 1);
    check("min_unstable", unstable_m, 0);
    @(posedge clk); #1;
    check("min_busy_fall", busy_m, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
